// File: rtl/proc_pkg.sv
// Shared processor definitions: writeback FSM states and ALU flag bit positions.
package proc_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } wb_state_t;

  localparam int FLAG_SAT = 4;
  localparam int FLAG_N   = 3;
  localparam int FLAG_Z   = 2;
  localparam int FLAG_C   = 1;
  localparam int FLAG_V   = 0;

endpackage

// File: rtl/writeback_sequencer_if.sv
// ALU-to-writeback handshake plus register-file write port and architectural flags.
interface writeback_sequencer_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] FinalResult;
  logic [DW-1:0] FinalResult2;
  logic [4:0]    ALUFlags;
  logic          wr1_en;
  logic          wr2_en;
  logic [AW-1:0] rd1;
  logic [AW-1:0] rd2;
  logic [1:0]    FlagWrite;
  logic          CondEx;
  logic          clr_q;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [3:0]    Flags;
  logic          q_flag;

  modport master (
    output in_valid, FinalResult, FinalResult2, ALUFlags, wr1_en, wr2_en,
           rd1, rd2, FlagWrite, CondEx, clr_q,
    input  in_ready, rf_we, rf_wa, rf_wd, Flags, q_flag
  );

  modport slave (
    input  in_valid, FinalResult, FinalResult2, ALUFlags, wr1_en, wr2_en,
           rd1, rd2, FlagWrite, CondEx, clr_q,
    output in_ready, rf_we, rf_wa, rf_wd, Flags, q_flag
  );
endinterface

// File: rtl/writeback_sequencer_flag_reg.sv
// NZCV register with per-pair update enables and optional sticky Q flag
// (Q present only when WB_SAT_STICKY_EN is defined).
module flag_reg
  import proc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       upd,
  input  logic [1:0] flag_write,
  input  logic [4:0] alu_flags,
  input  logic       clr_q,
  output logic [3:0] flags,
  output logic       q_flag
);

  logic [3:0] nzcv_q, nzcv_d;

  always_comb begin
    nzcv_d = nzcv_q;
    if (upd && flag_write[1]) begin
      nzcv_d[FLAG_N] = alu_flags[FLAG_N];
      nzcv_d[FLAG_Z] = alu_flags[FLAG_Z];
    end
    if (upd && flag_write[0]) begin
      nzcv_d[FLAG_C] = alu_flags[FLAG_C];
      nzcv_d[FLAG_V] = alu_flags[FLAG_V];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) nzcv_q <= 4'b0000;
    else        nzcv_q <= nzcv_d;
  end

  assign flags = nzcv_q;

`ifdef WB_SAT_STICKY_EN
  logic q_q, q_d;

  // Set is applied after clear so a concurrent saturation keeps Q high.
  always_comb begin
    q_d = q_q;
    if (clr_q) q_d = 1'b0;
    if (upd && (|flag_write) && alu_flags[FLAG_SAT]) q_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q_flag = q_q;
`else
  logic unused_sat;
  assign unused_sat = &{1'b0, clr_q, alu_flags[FLAG_SAT]};
  assign q_flag     = 1'b0;
`endif

endmodule

// File: rtl/writeback_sequencer.sv
// Writeback stage: registers ALU results onto one register-file write port,
// serialising dual-result ops, and holds NZCV/Q flags (Q under WB_SAT_STICKY_EN).
module writeback_sequencer
  import proc_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic                clk,
  input  logic                reset,
  writeback_sequencer_if.slave wb
);

  wb_state_t     state_q, state_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_wa_q, rf_wa_d;
  logic [DW-1:0] rf_wd_q, rf_wd_d;
  logic [AW-1:0] hi_wa_q, hi_wa_d;
  logic [DW-1:0] hi_wd_q, hi_wd_d;
  logic          in_ready;
  logic          go;

  assign in_ready = (state_q == IDLE);
  assign go       = wb.in_valid && in_ready && wb.CondEx;

  always_comb begin
    state_d = state_q;
    rf_we_d = 1'b0;
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    hi_wa_d = hi_wa_q;
    hi_wd_d = hi_wd_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          if (wb.wr1_en) begin
            rf_we_d = 1'b1;
            rf_wa_d = wb.rd1;
            rf_wd_d = wb.FinalResult;
            if (wb.wr2_en) begin
              hi_wa_d = wb.rd2;
              hi_wd_d = wb.FinalResult2;
              state_d = SECOND;
            end
          end else if (wb.wr2_en) begin
            // A lone hi-word write needs no serialisation slot.
            rf_we_d = 1'b1;
            rf_wa_d = wb.rd2;
            rf_wd_d = wb.FinalResult2;
          end
        end
      end
      SECOND: begin
        rf_we_d = 1'b1;
        rf_wa_d = hi_wa_q;
        rf_wd_d = hi_wd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rf_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
      hi_wa_q <= '0;
      hi_wd_q <= '0;
    end else begin
      state_q <= state_d;
      rf_we_q <= rf_we_d;
      rf_wa_q <= rf_wa_d;
      rf_wd_q <= rf_wd_d;
      hi_wa_q <= hi_wa_d;
      hi_wd_q <= hi_wd_d;
    end
  end

  logic [3:0] flags;
  logic       q_flag;

  flag_reg u_flag_reg (
    .clk        (clk),
    .reset      (reset),
    .upd        (go),
    .flag_write (wb.FlagWrite),
    .alu_flags  (wb.ALUFlags),
    .clr_q      (wb.clr_q),
    .flags      (flags),
    .q_flag     (q_flag)
  );

  assign wb.in_ready = in_ready;
  assign wb.rf_we    = rf_we_q;
  assign wb.rf_wa    = rf_wa_q;
  assign wb.rf_wd    = rf_wd_q;
  assign wb.Flags    = flags;
  assign wb.q_flag   = q_flag;

endmodule

// File: tb/tb_writeback_sequencer.sv
// Directed bench for writeback_sequencer: vector table plus hand-written multi-cycle sequences.
module tb_writeback_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  writeback_sequencer_if #(.DW(32), .AW(4)) wb ();

  writeback_sequencer #(.DW(32), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] fr;
    logic [31:0] fr2;
    logic [4:0]  alu;
    logic        wr1;
    logic        wr2;
    logic [3:0]  rd1;
    logic [3:0]  rd2;
    logic [1:0]  fw;
    logic        cond;
    logic        e_we;
    logic [3:0]  e_wa;
    logic [31:0] e_wd;
    logic [3:0]  e_flags;
  } vec_t;

  vec_t vecs[8];

  task automatic drive(input logic valid, input logic [31:0] fr, input logic [31:0] fr2,
                       input logic [4:0] alu, input logic wr1, input logic wr2,
                       input logic [3:0] rd1, input logic [3:0] rd2,
                       input logic [1:0] fw, input logic cond, input logic clr);
    wb.in_valid     = valid;
    wb.FinalResult  = fr;
    wb.FinalResult2 = fr2;
    wb.ALUFlags     = alu;
    wb.wr1_en       = wr1;
    wb.wr2_en       = wr2;
    wb.rd1          = rd1;
    wb.rd2          = rd2;
    wb.FlagWrite    = fw;
    wb.CondEx       = cond;
    wb.clr_q        = clr;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 5'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [3:0] wa, input logic [31:0] wd);
    chk({tag, ".rf_we"}, {31'b0, wb.rf_we}, {31'b0, we});
    chk({tag, ".rf_wa"}, {28'b0, wb.rf_wa}, {28'b0, wa});
    chk({tag, ".rf_wd"}, wb.rf_wd, wd);
  endtask

  task automatic chk_q(input string tag, input logic exp_when_en);
`ifdef WB_SAT_STICKY_EN
    chk(tag, {31'b0, wb.q_flag}, {31'b0, exp_when_en});
`else
    chk(tag, {31'b0, wb.q_flag}, 32'd0);
`endif
  endtask

  task automatic chk_reset_state(input string tag);
    chk_rf(tag, 1'b0, 4'd0, 32'h0);
    chk({tag, ".in_ready"}, {31'b0, wb.in_ready}, 32'd1);
    chk({tag, ".Flags"}, {28'b0, wb.Flags}, 32'd0);
    chk({tag, ".q_flag"}, {31'b0, wb.q_flag}, 32'd0);
  endtask

  initial begin
    //                valid fr            fr2           alu       wr1  wr2  rd1 rd2 fw     cond  we  wa  wd            flags
    vecs[0] = '{1'b1, 32'h0000_00AA, 32'h0,         5'b0_0000, 1'b1, 1'b0, 4'd3, 4'd0, 2'b00, 1'b1, 1'b1, 4'd3, 32'h0000_00AA, 4'b0000};
    vecs[1] = '{1'b0, 32'h0,         32'h0,         5'b0_0000, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 4'd3, 32'h0000_00AA, 4'b0000};
    vecs[2] = '{1'b1, 32'h0,         32'h0,         5'b0_1001, 1'b0, 1'b0, 4'd0, 4'd0, 2'b10, 1'b1, 1'b0, 4'd3, 32'h0000_00AA, 4'b1000};
    vecs[3] = '{1'b1, 32'h0,         32'h0,         5'b0_0011, 1'b0, 1'b0, 4'd0, 4'd0, 2'b01, 1'b1, 1'b0, 4'd3, 32'h0000_00AA, 4'b1011};
    vecs[4] = '{1'b1, 32'h0000_0055, 32'h0,         5'b0_0000, 1'b1, 1'b0, 4'd7, 4'd0, 2'b11, 1'b0, 1'b0, 4'd3, 32'h0000_00AA, 4'b1011};
    vecs[5] = '{1'b1, 32'h0,         32'h0000_1234, 5'b0_0000, 1'b0, 1'b1, 4'd0, 4'd9, 2'b00, 1'b1, 1'b1, 4'd9, 32'h0000_1234, 4'b1011};
    vecs[6] = '{1'b0, 32'h0000_0077, 32'h0,         5'b0_1111, 1'b1, 1'b0, 4'd8, 4'd0, 2'b11, 1'b1, 1'b0, 4'd9, 32'h0000_1234, 4'b1011};
    vecs[7] = '{1'b1, 32'h0,         32'h0,         5'b0_0100, 1'b1, 1'b0, 4'd1, 4'd0, 2'b11, 1'b1, 1'b1, 4'd1, 32'h0000_0000, 4'b0100};

    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("init");
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].valid, vecs[i].fr, vecs[i].fr2, vecs[i].alu, vecs[i].wr1, vecs[i].wr2,
            vecs[i].rd1, vecs[i].rd2, vecs[i].fw, vecs[i].cond, 1'b0);
      tick();
      chk_rf($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_wa, vecs[i].e_wd);
      chk($sformatf("vec%0d.Flags", i), {28'b0, wb.Flags}, {28'b0, vecs[i].e_flags});
      chk($sformatf("vec%0d.in_ready", i), {31'b0, wb.in_ready}, 32'd1);
    end

    // Long multiply with a second op waiting behind it.
    drive(1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 5'b0, 1'b1, 1'b1, 4'd4, 4'd5, 2'b00, 1'b1, 1'b0);
    tick();
    chk_rf("lmul+1", 1'b1, 4'd4, 32'hFFFF_FFFE);
    chk("lmul+1.in_ready", {31'b0, wb.in_ready}, 32'd0);
    drive(1'b1, 32'h0000_0066, 32'h0, 5'b0, 1'b1, 1'b0, 4'd6, 4'd0, 2'b00, 1'b1, 1'b0);
    tick();
    chk_rf("lmul+2", 1'b1, 4'd5, 32'h0000_0001);
    chk("lmul+2.in_ready", {31'b0, wb.in_ready}, 32'd1);
    tick();
    chk_rf("held_op", 1'b1, 4'd6, 32'h0000_0066);
    idle();
    tick();
    chk_rf("after_held", 1'b0, 4'd6, 32'h0000_0066);

    // Dual write to the same register: hi word lands last.
    drive(1'b1, 32'h0000_0011, 32'h0000_0022, 5'b0, 1'b1, 1'b1, 4'd2, 4'd2, 2'b00, 1'b1, 1'b0);
    tick();
    idle();
    chk_rf("same_rd+1", 1'b1, 4'd2, 32'h0000_0011);
    tick();
    chk_rf("same_rd+2", 1'b1, 4'd2, 32'h0000_0022);

    // Sticky Q.
    drive(1'b1, 32'h0, 32'h0, 5'b1_0000, 1'b0, 1'b0, 4'd0, 4'd0, 2'b01, 1'b1, 1'b0);
    tick();
    chk_q("q_set", 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h0, 32'h0, 5'b0_0000, 1'b0, 1'b0, 4'd0, 4'd0, 2'b01, 1'b1, 1'b0);
      tick();
      chk_q($sformatf("q_hold%0d", k), 1'b1);
    end
    drive(1'b1, 32'h0, 32'h0, 5'b1_0000, 1'b0, 1'b0, 4'd0, 4'd0, 2'b01, 1'b1, 1'b1);
    tick();
    chk_q("q_set_wins", 1'b1);
    drive(1'b0, 32'h0, 32'h0, 5'b0_0000, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 1'b1, 1'b1);
    tick();
    chk_q("q_clr", 1'b0);
    drive(1'b1, 32'h0, 32'h0, 5'b1_0000, 1'b0, 1'b0, 4'd0, 4'd0, 2'b01, 1'b1, 1'b0);
    tick();
    chk_q("q_set_again", 1'b1);

    // Reset asserted while a hi-word write is pending.
    drive(1'b1, 32'h0000_00A1, 32'h0000_00B2, 5'b0_1111, 1'b1, 1'b1, 4'd10, 4'd11, 2'b11, 1'b1, 1'b0);
    tick();
    idle();
    chk_rf("pre_rst", 1'b1, 4'd10, 32'h0000_00A1);
    chk("pre_rst.Flags", {28'b0, wb.Flags}, 32'h0000_000F);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_state("async_rst");
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk_rf("post_rst", 1'b0, 4'd0, 32'h0);
    chk("post_rst.in_ready", {31'b0, wb.in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
